alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Requester side of the 8-bit ALU interface. Accepts operation requests over valid/ready and drives the
//  ALU's a/b/f inputs. Captures y/zero into a held response register. Sequences a multi-cycle MUL as repeated
//  ALU adds. Sits between a command source (test sequencer/control) and an external 8-bit ALU instance.
// PARAMETERS
//  WIDTH   8  datapath width; fixed at 8 to match the ALU.
//  MUL_EN  1  1: OP_MUL iterates; 0: OP_MUL executes as OP_ADD.
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset_n    in   1      asynchronous, active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      request accepted on the edge where valid&&ready
//  req_op     in   2      alu_op_t: OP_ADD, OP_SUB, OP_CMP, OP_MUL
//  req_a      in   WIDTH  operand A
//  req_b      in   WIDTH  operand B (MUL: iteration count)
//  alu_a      out  WIDTH  to ALU a
//  alu_b      out  WIDTH  to ALU b
//  alu_f      out  1      to ALU f (0 add, 1 subtract)
//  alu_y      in   WIDTH  from ALU y
//  alu_zero   in   1      from ALU zero; always reflects (a-b)==0, regardless of f
//  rsp_valid  out  1      response held until consumed
//  rsp_ready  in   1      consumer accepts on the edge where valid&&ready
//  rsp_data   out  WIDTH  result
//  rsp_zero   out  1      result-zero / equal flag
//  busy       out  1      state != S_IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state S_IDLE, rsp_valid=0, rsp_data=0, rsp_zero=0, busy=0.
//    alu_a/alu_b/alu_f are 0 while in S_IDLE.
//  - req_ready = (state==S_IDLE) && (!rsp_valid || rsp_ready). Pop and accept may share an edge.
//  - On accept, opA/opB/op are latched. Next state:
//    S_MUL if op==OP_MUL && MUL_EN && req_b!=0; otherwise S_EXEC.
//    For MUL with b==0, S_EXEC returns data=0, zero=1.
//  - S_EXEC (1 cycle): alu_a=opA, alu_b=opB, alu_f=(op!=OP_ADD). On exit edge, load the response and go to S_IDLE:
//    ADD: data=alu_y, zero=(alu_y==0), computed locally because the ALU zero reports the subtract.
//    SUB: data=alu_y, zero=alu_zero.
//    CMP: data={7'b0,alu_zero}, zero=alu_zero.
//  - S_MUL: acc starts at 0, cnt=opB. Each cycle: alu_a=acc, alu_b=opA, alu_f=0; acc<=alu_y; cnt<=cnt-1.
//    On the cycle cnt==1: load data=alu_y, zero=(alu_y==0), go to S_IDLE.
//    Result is the low 8 bits of A*B; overflow wraps silently.
//  - Latency (accept edge = E): ADD/SUB/CMP/MUL(b=0): rsp_valid high after E+1. MUL(b=n): rsp_valid high after E+n.
//  - rsp_data/rsp_zero are stable while rsp_valid && !rsp_ready. rsp_valid clears on the pop edge unless a new
//    response loads on the same edge. That cannot happen: a new response needs >=1 edge after accept.
//  - A response is only loaded from S_EXEC/S_MUL, so the slot is always free there; no internal stall state.
//  - reset_n low mid-operation: aborts immediately, discards the operation and any pending response; no response issued.
//  - req_* are ignored while !req_ready. The cnt counter is WIDTH bits and never underflows (exit at 1).
// STRUCTURE
//  - Package alu_issue_pkg: typedef enum logic [1:0] alu_op_t {OP_ADD=0, OP_SUB=1, OP_CMP=2, OP_MUL=3};
//    typedef enum state_t {S_IDLE, S_EXEC, S_MUL}; localparams ALU_F_ADD=1'b0, ALU_F_SUB=1'b1.
//  - No sub-module: one FSM plus operand/acc/cnt/response registers. The ALU is instantiated beside this block
//    (bench and top-level), not inside it.
// TESTING (bench instantiates alu_issue_ctrl + ALU, rsp_ready=1 unless stated)
//  1. ADD 8'h7F,8'h01 -> rsp_data=8'h80, rsp_zero=0, rsp_valid after accept edge +1; busy high 1 cycle.
//  2. ADD 8'hFF,8'h01 -> data=8'h00, zero=1 while ALU zero=0. SUB 8'h05,8'h05 -> data=8'h00, zero=1.
//     SUB 8'h03,8'h05 -> data=8'hFE, zero=0.
//  3. CMP 8'h10,8'h10 -> data=8'h01, zero=1. CMP 8'h10,8'h11 -> data=8'h00, zero=0.
//  4. MUL 8'h03,8'h05 -> 8'h0F after E+5. MUL 8'h20,8'h10 -> 8'h00, zero=1 (wrap).
//     MUL 8'h07,8'h00 -> 8'h00, zero=1 after E+1. MUL_EN=0: MUL 3,5 -> 8'h08.
//  5. Backpressure: rsp_ready=0 for 5 cycles -> rsp_data/zero stable, req_ready=0. Raise rsp_ready with
//     req_valid -> pop and accept on the same edge; next response 2 edges later.
//  6. Assert reset_n low mid-MUL 8'h02,8'h0A -> immediately state S_IDLE, rsp_valid=0, alu_* =0.
//     No response after release; next ADD 1,1 -> 8'h02.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue controller.
// Op codes, FSM states and ALU function-select encodings.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_CMP = 2'd2,
    OP_MUL = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  localparam logic ALU_F_ADD = 1'b0;
  localparam logic ALU_F_SUB = 1'b1;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Requester side of an external 8-bit ALU: takes op requests
// over valid/ready, drives ALU a/b/f, holds one response.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   req_valid/ready/op/a/b    request handshake and operands
//   alu_a/b/f                 drive to external ALU
//   alu_y/zero                result and (a-b)==0 from ALU
//   rsp_valid/ready/data/zero held response handshake
//   busy                      FSM not idle
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  alu_op_t          req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
);

  state_t           r_state;
  alu_op_t          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_cnt;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;

  logic             w_accept;
  logic             w_mul_iter;
  logic             w_y_zero;

  assign req_ready = (r_state == S_IDLE)
                   && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_mul_iter = (req_op == OP_MUL) && MUL_EN
                    && (req_b != '0);
  // ALU zero always reflects the subtract, so add
  // results need their own zero detect.
  assign w_y_zero  = (alu_y == '0);

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = ALU_F_ADD;
    unique case (r_state)
      S_EXEC: begin
        alu_a = r_a;
        alu_b = r_b;
        alu_f = (r_op == OP_ADD) ? ALU_F_ADD : ALU_F_SUB;
      end
      S_MUL: begin
        alu_a = r_acc;
        alu_b = r_a;
        alu_f = ALU_F_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
    end else begin
      if (r_rsp_valid && rsp_ready)
        r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= req_a;
            r_b   <= req_b;
            r_acc <= '0;
            r_cnt <= req_b;
            // With MUL disabled the op degrades to ADD.
            r_op  <= (req_op == OP_MUL && !MUL_EN)
                   ? OP_ADD : req_op;
            r_state <= w_mul_iter ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_IDLE;
          unique case (r_op)
            OP_ADD: begin
              r_rsp_data <= alu_y;
              r_rsp_zero <= w_y_zero;
            end
            OP_SUB: begin
              r_rsp_data <= alu_y;
              r_rsp_zero <= alu_zero;
            end
            OP_CMP: begin
              r_rsp_data <= {{(WIDTH-1){1'b0}}, alu_zero};
              r_rsp_zero <= alu_zero;
            end
            OP_MUL: begin
              // Only reached with a zero count.
              r_rsp_data <= '0;
              r_rsp_zero <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MUL: begin
          r_acc <= alu_y;
          r_cnt <= r_cnt - WIDTH'(1);
          if (r_cnt == WIDTH'(1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= alu_y;
            r_rsp_zero  <= w_y_zero;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU beside it.
// Vector table plus backpressure, reset and MUL_EN=0 cases.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_valid1;
  logic       req_ready;
  logic       req_ready1;
  alu_op_t    req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_f, alu_zero;
  logic [7:0] alu_a1, alu_b1, alu_y1;
  logic       alu_f1, alu_zero1;
  logic       rsp_valid, rsp_ready, rsp_zero, busy;
  logic [7:0] rsp_data;
  logic       rsp_valid1, rsp_zero1, busy1;
  logic [7:0] rsp_data1;

  int n_tests = 0;
  int n_fail  = 0;

  assign alu_y     = alu_f ? alu_a - alu_b : alu_a + alu_b;
  assign alu_zero  = ((alu_a - alu_b) == 8'h00);
  assign alu_y1    = alu_f1 ? alu_a1 - alu_b1 : alu_a1 + alu_b1;
  assign alu_zero1 = ((alu_a1 - alu_b1) == 8'h00);

  alu_issue_ctrl #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  alu_issue_ctrl #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_f(alu_f1),
    .alu_y(alu_y1), .alu_zero(alu_zero1),
    .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
    .rsp_data(rsp_data1), .rsp_zero(rsp_zero1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_t    op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       zero;
    int         lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Issue one op on the MUL_EN=1 instance and wait for
  // its response; lat counts edges from accept edge.
  task automatic run_op(input alu_op_t op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        output logic [7:0] d,
                        output logic z,
                        output int lat,
                        output int bcnt);
    int n;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; bcnt = 0;
    while (!rsp_valid && lat < 300) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    d = rsp_data;
    z = rsp_zero;
    if (!rsp_valid)
      check("rsp_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] d;
  logic       z;
  int         lat, bcnt, seen;
  logic [7:0] hold_d;
  logic       hold_z;

  initial begin
    vecs[0] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1};
    vecs[1] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1};
    vecs[2] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1};
    vecs[3] = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1};
    vecs[4] = '{OP_CMP, 8'h10, 8'h10, 8'h01, 1'b1, 1};
    vecs[5] = '{OP_CMP, 8'h10, 8'h11, 8'h00, 1'b0, 1};
    vecs[6] = '{OP_MUL, 8'h03, 8'h05, 8'h0F, 1'b0, 5};
    vecs[7] = '{OP_MUL, 8'h20, 8'h10, 8'h00, 1'b1, 16};
    vecs[8] = '{OP_MUL, 8'h07, 8'h00, 8'h00, 1'b1, 1};

    reset_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
    req_op = OP_ADD; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    #12;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu", {15'd0, alu_f, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             d, z, lat, bcnt);
      check($sformatf("v%0d_data", i), {24'd0, d},
            {24'd0, vecs[i].data});
      check($sformatf("v%0d_zero", i), {31'd0, z},
            {31'd0, vecs[i].zero});
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bcnt, vecs[i].lat);
      @(posedge clk); #1;
      check($sformatf("v%0d_pop", i),
            {31'd0, rsp_valid}, 32'd0);
    end

    // ALU zero flag is low during ADD FF+01 even though
    // the sum is zero.
    @(negedge clk);
    req_op = OP_ADD; req_a = 8'hFF; req_b = 8'h01;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("add_alu_zero", {31'd0, alu_zero}, 32'd0);
    check("add_alu_f", {31'd0, alu_f}, 32'd0);
    @(posedge clk); #1;
    check("add_wrap_zero", {31'd0, rsp_zero}, 32'd1);
    @(posedge clk); #1;

    // MUL_EN=0 instance: MUL 3,5 behaves as ADD.
    @(negedge clk);
    req_op = OP_MUL; req_a = 8'h03; req_b = 8'h05;
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(posedge clk); #1;
    check("nomul_valid", {31'd0, rsp_valid1}, 32'd1);
    check("nomul_data", {24'd0, rsp_data1}, 32'h08);
    check("nomul_zero", {31'd0, rsp_zero1}, 32'd0);

    // Backpressure: hold response, then pop+accept on
    // one edge.
    rsp_ready = 1'b0;
    run_op(OP_ADD, 8'h7F, 8'h01, d, z, lat, bcnt);
    hold_d = d; hold_z = z;
    req_op = OP_SUB; req_a = 8'h05; req_b = 8'h05;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", {24'd0, rsp_data}, {24'd0, hold_d});
      check("bp_zero", {31'd0, rsp_zero}, {31'd0, hold_z});
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("bp_data_val", {24'd0, hold_d}, 32'h80);
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_rise", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_pop", {31'd0, rsp_valid}, 32'd0);
    check("bp_accept", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_next_data", {24'd0, rsp_data}, 32'h00);
    check("bp_next_zero", {31'd0, rsp_zero}, 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of MUL 2 x 10.
    @(negedge clk);
    req_op = OP_MUL; req_a = 8'h02; req_b = 8'h0A;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mul_mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mrst_alu", {15'd0, alu_f, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen++;
    end
    check("mrst_no_rsp", seen, 0);
    run_op(OP_ADD, 8'h01, 8'h01, d, z, lat, bcnt);
    check("post_rst_data", {24'd0, d}, 32'h02);
    check("post_rst_zero", {31'd0, z}, 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
